// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and constants for the two-input arbiter in front of the 2:1 mux stage.
package mux_arb_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic SEL_DIN0       = 1'b0;
  localparam logic SEL_DIN1       = 1'b1;
  localparam logic LAST_GRANT_RST = 1'b1;

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between the two sources, the arbiter and the mux consumer.
// master = arbiter side, slave = sources/consumer side.
interface mux_rr_arbiter_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] din_0;
  logic             din_0_valid;
  logic             din_0_ready;
  logic [WIDTH-1:0] din_1;
  logic             din_1_valid;
  logic             din_1_ready;
  logic [WIDTH-1:0] mux_out;
  logic             out_valid;
  logic             out_ready;
  logic             sel;

  modport master (
    input  din_0, din_0_valid, din_1, din_1_valid, out_ready,
    output din_0_ready, din_1_ready, mux_out, out_valid, sel
  );

  modport slave (
    output din_0, din_0_valid, din_1, din_1_valid, out_ready,
    input  din_0_ready, din_1_ready, mux_out, out_valid, sel
  );
endinterface

// File: rtl/mux_rr_arbiter_pick.sv
// Combinational grant pick for two requesters; ties follow last_grant, or go to din_1 under MUX_ARB_FIXED_PRIO_EN.
// Latency: zero (pure logic). Backpressure: no grant at all while can_load is low.
module mux_arb_pick (
  input  logic v0,
  input  logic v1,
  input  logic last_grant,
  input  logic can_load,
  output logic grant_0,
  output logic grant_1
);

`ifdef MUX_ARB_FIXED_PRIO_EN
  assign grant_0 = can_load & v0 & ~v1;
  assign grant_1 = can_load & v1;
`else
  // On a tie the source that did not win last time gets the slot.
  assign grant_0 = can_load & v0 & (~v1 | last_grant);
  assign grant_1 = can_load & v1 & (~v0 | ~last_grant);
`endif

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter registering the winning word and the mux select (MUX_ARB_FIXED_PRIO_EN: ties go to din_1).
// Latency: one cycle from input handshake to out_valid; drain and load overlap for one word per cycle.
// Backpressure: while full and out_ready is low, word/sel hold and both readys stay low.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input logic              clk,
  input logic              rst,
  mux_rr_arbiter_if.master bus
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_mux_out;
  logic [WIDTH-1:0] w_mux_out_nxt;
  logic             r_sel;
  logic             w_sel_nxt;
  logic             w_last_grant;
  logic             w_can_load;
  logic             w_grant_0;
  logic             w_grant_1;
  logic             w_load;

  // Readys are forced low while rst is high, even though state resets on the edge.
  assign w_can_load = ~rst & ((r_state == EMPTY) | bus.out_ready);
  assign w_load     = w_grant_0 | w_grant_1;

  mux_arb_pick u_pick (
    .v0         (bus.din_0_valid),
    .v1         (bus.din_1_valid),
    .last_grant (w_last_grant),
    .can_load   (w_can_load),
    .grant_0    (w_grant_0),
    .grant_1    (w_grant_1)
  );

`ifdef MUX_ARB_FIXED_PRIO_EN
  assign w_last_grant = LAST_GRANT_RST;
`else
  logic r_last_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= LAST_GRANT_RST;
    end else if (w_load) begin
      r_last_grant <= w_grant_1;
    end
  end

  assign w_last_grant = r_last_grant;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_mux_out_nxt = r_mux_out;
    w_sel_nxt     = r_sel;
    if (w_load) begin
      w_state_nxt   = FULL;
      w_mux_out_nxt = w_grant_1 ? bus.din_1 : bus.din_0;
      w_sel_nxt     = w_grant_1 ? SEL_DIN1 : SEL_DIN0;
    end else begin
      case (r_state)
        EMPTY:   w_state_nxt = EMPTY;
        FULL:    w_state_nxt = bus.out_ready ? EMPTY : FULL;
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= EMPTY;
      r_mux_out <= '0;
      r_sel     <= SEL_DIN0;
    end else begin
      r_state   <= w_state_nxt;
      r_mux_out <= w_mux_out_nxt;
      r_sel     <= w_sel_nxt;
    end
  end

  assign bus.din_0_ready = w_grant_0;
  assign bus.din_1_ready = w_grant_1;
  assign bus.mux_out     = r_mux_out;
  assign bus.sel         = r_sel;
  assign bus.out_valid   = (r_state == FULL);

endmodule
